// File: rtl/fifo_uart_tx_12bit.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_12bit
//
// Reads 12-bit sample words from the read side of the 16x12 sample FIFO and
// sends each word to the host over a UART line. Each word goes out as two
// 8N1 frames, LSB first:
//   byte0 = {2'b10, word[11:6]}  -- bit7 set marks the first byte of a word
//   byte1 = {2'b00, word[5:0]}
// One word takes 20*CLKS_PER_BIT cycles on the line. Words sent back to back
// have a 2-cycle idle-high gap between them (the POP and LATCH cycles).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit, 2..65535 (434 = 50 MHz / 115200)
//   CNT_WIDTH     width of the baud counter; must hold CLKS_PER_BIT-1
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset. It aborts any word in flight
//               and drives tx high at once.
//   enable      level; allows a new word to start (a word in flight always
//               completes)
//   fifo_empty  FIFO empty flag; sampled only in IDLE and at the end of a
//               word's final stop bit
//   fifo_data   FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle FIFO read strobe
//   tx          UART serial line, idle high
//   busy        high from the POP cycle to the end of the last stop bit
//   words_sent  count of fully transmitted words, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo_uart_tx_12bit #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [11:0] fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] words_sent
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] IDLE  = 3'd0;  // line idle, waiting for a word
  localparam logic [2:0] POP   = 3'd1;  // read strobe to the FIFO
  localparam logic [2:0] LATCH = 3'd2;  // capture the FIFO's registered data
  localparam logic [2:0] START = 3'd3;  // start bit (low)
  localparam logic [2:0] DATA  = 3'd4;  // 8 data bits, LSB first
  localparam logic [2:0] STOP  = 3'd5;  // stop bit (high)

  // Last value of the baud counter within one bit period.
  localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // Internal signals
  // ---------------------------------------------------------------------------
  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [CNT_WIDTH-1:0] baud_cnt;
  logic                 bit_done;    // final cycle of the current bit period
  logic [2:0]           bit_idx;     // data bit being sent, 0..7
  logic                 byte_sel;    // 0: sending byte0, 1: sending byte1
  logic [11:0]          word_reg;    // word being sent
  logic [7:0]           shift_reg;   // byte being serialised; bit0 on the line
  logic                 word_ready;  // a new word may start
  logic                 tx_next;

  assign bit_done   = (baud_cnt == BAUD_LAST);
  assign word_ready = enable && !fifo_empty;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default before the case so every path sets state_next;
    // otherwise synthesis infers a latch.
    state_next = state;
    case (state)
      IDLE:  if (word_ready) state_next = POP;
      POP:   state_next = LATCH;
      LATCH: state_next = START;
      START: if (bit_done) state_next = DATA;
      DATA:  if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
      STOP: begin
        if (bit_done) begin
          if (!byte_sel)       state_next = START;  // byte1 follows, no gap
          else if (word_ready) state_next = POP;    // next word, 2-cycle gap
          else                 state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, whatever order the blocks are evaluated in.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Baud counter: runs only while a frame is on the line. It restarts at 0 on
  // every bit boundary, so each bit lasts exactly CLKS_PER_BIT cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if ((state == START) || (state == DATA) || (state == STOP)) begin
      if (bit_done) baud_cnt <= '0;
      else          baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Word / byte datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_reg  <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
      byte_sel  <= 1'b0;
    end else begin
      case (state)
        LATCH: begin
          // fifo_data is valid in this cycle only, one cycle after the strobe.
          word_reg  <= fifo_data;
          shift_reg <= {2'b10, fifo_data[11:6]};
          byte_sel  <= 1'b0;
          bit_idx   <= '0;
        end
        START: begin
          if (bit_done) bit_idx <= '0;
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (bit_done && !byte_sel) begin
            shift_reg <= {2'b00, word_reg[5:0]};
            byte_sel  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serial line value for the next cycle. tx is registered so the line never
  // glitches on state decoding.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START: tx_next = 1'b0;
      DATA: begin
        if (state == START)  tx_next = shift_reg[0];  // first data bit
        else if (bit_done)   tx_next = shift_reg[1];  // bit about to shift in
        else                 tx_next = tx;            // hold within the bit
      end
      default: tx_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. tx resets to 1, so an asserted rst drives the line
  // idle-high at once, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
    end else begin
      tx         <= tx_next;
      // The strobe is decided from fifo_empty in the cycle before POP. The
      // FIFO cannot go empty without a read, so it is still non-empty here.
      fifo_rd_en <= (state_next == POP);
      busy       <= (state_next != IDLE);
      if ((state == STOP) && bit_done && byte_sel)
        words_sent <= words_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_12bit.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx_12bit
//
// Testbench for fifo_uart_tx_12bit with CLKS_PER_BIT = 4. A simple FIFO model
// feeds the design. A line monitor decodes the 8N1 frames that appear on tx
// and requires each bit to hold a constant value for CLKS_PER_BIT cycles.
// Expected bytes are worked out from the words pushed into the FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx_12bit;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic [11:0] fifo_data = '0;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] words_sent;

  fifo_uart_tx_12bit #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FIFO model (registered read data) ----------------
  logic [11:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_data <= fifo_mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [11:0] w);
    fifo_mem[wr_ptr % 256] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // ---------------- read-strobe monitor ----------------
  int pop_cyc[$];
  int rd_empty_viol = 0;
  int rd_long = 0;

  initial begin : rd_mon
    bit rd_prev;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        if (fifo_empty) rd_empty_viol++;
        if (rd_prev) rd_long++;
        else         pop_cyc.push_back(cyc);
      end
      rd_prev = (fifo_rd_en === 1'b1);
    end
  end

  // ---------------- line monitor ----------------
  logic [7:0] rx_bytes[$];
  int rx_start[$];
  int bad_frames = 0;

  initial begin : line_mon
    logic [9:0] frame;
    bit ok;
    bit aborted;
    int st;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        aborted = 1'b0;
        frame = '0;
        for (int k = 0; k < 10 * CPB && !aborted; k++) begin
          if (k != 0) @(negedge clk);
          if (rst !== 1'b0)     aborted = 1'b1;
          else if (k % CPB == 0) frame[k / CPB] = tx;
          else if (tx !== frame[k / CPB]) ok = 1'b0;
        end
        if (!aborted) begin
          if (!ok || frame[0] != 1'b0 || frame[9] != 1'b1) bad_frames++;
          rx_bytes.push_back(frame[8:1]);
          rx_start.push_back(st);
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Both bytes of word w, starting at rx index idx, plus their spacing.
  task automatic check_word(input string tag, input int idx, input logic [11:0] w);
    int exp0;
    int exp1;
    exp0 = 128 + (int'(w) / 64);
    exp1 = int'(w) % 64;
    if (rx_bytes.size() >= idx + 2) begin
      check({tag, "_byte0"}, 32'(rx_bytes[idx]), 32'(exp0));
      check({tag, "_byte1"}, 32'(rx_bytes[idx + 1]), 32'(exp1));
      check({tag, "_byte_spacing"}, rx_start[idx + 1] - rx_start[idx], 10 * CPB);
    end else begin
      check({tag, "_bytes_present"}, rx_bytes.size(), idx + 2);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((busy || (enable && !fifo_empty)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_done_in_time"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_pop(input string tag, input int pbase, output int pc);
    int n;
    n = 0;
    while (pop_cyc.size() <= pbase && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pop_seen"}, 32'(pop_cyc.size() > pbase), 32'd1);
    pc = (pop_cyc.size() > pbase) ? pop_cyc[pbase] : cyc;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] exp_ws;
  int rb;
  int pb;
  int pc;
  logic [11:0] w0;
  logic [11:0] w1;
  logic [11:0] ws[4];
  int nw;

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    exp_ws = '0;

    // Reset values, with the FIFO empty.
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_words", words_sent, 0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_tx", tx, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_pops", pop_cyc.size(), 0);
    check("post_rst_words", words_sent, 0);

    // Single word 0xABC.
    rb = rx_bytes.size();
    pb = pop_cyc.size();
    push(12'hABC);
    wait_pop("single", pb, pc);
    wait_idle("single", 300);
    exp_ws = exp_ws + 16'd1;
    check("single_nbytes", rx_bytes.size() - rb, 2);
    check_word("single", rb, 12'hABC);
    if (rx_start.size() > rb)
      check("single_latency", rx_start[rb] - pc, 2);
    check("single_npops", pop_cyc.size() - pb, 1);
    check("single_words", words_sent, 32'(exp_ws));
    check("single_busy", busy, 0);

    // Three words queued back to back.
    enable = 1'b0;
    push(12'h000);
    push(12'hFFF);
    push(12'h03F);
    rb = rx_bytes.size();
    pb = pop_cyc.size();
    @(negedge clk);
    enable = 1'b1;
    wait_idle("b2b", 600);
    exp_ws = exp_ws + 16'd3;
    check("b2b_nbytes", rx_bytes.size() - rb, 6);
    check_word("b2b_w0", rb, 12'h000);
    check_word("b2b_w1", rb + 2, 12'hFFF);
    check_word("b2b_w2", rb + 4, 12'h03F);
    if (rx_start.size() >= rb + 6) begin
      check("b2b_gap01", rx_start[rb + 2] - (rx_start[rb + 1] + 10 * CPB), 2);
      check("b2b_gap12", rx_start[rb + 4] - (rx_start[rb + 3] + 10 * CPB), 2);
    end
    check("b2b_npops", pop_cyc.size() - pb, 3);
    check("b2b_words", words_sent, 32'(exp_ws));

    // enable dropped during byte0's data bits, with 2 words queued.
    enable = 1'b0;
    w0 = 12'($urandom);
    w1 = 12'($urandom);
    push(w0);
    push(w1);
    rb = rx_bytes.size();
    pb = pop_cyc.size();
    @(negedge clk);
    enable = 1'b1;
    wait_pop("endrop", pb, pc);
    wait_cyc(pc + 2 + CPB + 2 * CPB + 1);
    enable = 1'b0;
    wait_idle("endrop", 300);
    exp_ws = exp_ws + 16'd1;
    check("endrop_nbytes", rx_bytes.size() - rb, 2);
    check_word("endrop", rb, w0);
    check("endrop_npops", pop_cyc.size() - pb, 1);
    check("endrop_fifo_count", wr_ptr - rd_ptr, 1);
    check("endrop_busy", busy, 0);
    check("endrop_words", words_sent, 32'(exp_ws));
    // Drain the remaining word.
    rb = rx_bytes.size();
    enable = 1'b1;
    wait_idle("endrop_drain", 300);
    exp_ws = exp_ws + 16'd1;
    check_word("endrop_drain", rb, w1);
    check("endrop_drain_words", words_sent, 32'(exp_ws));

    // Reset during bit 3 of byte1 (w0[3] = 0, so the line is low at that point).
    enable = 1'b0;
    w0 = 12'($urandom) & 12'hFF7;
    w1 = 12'($urandom);
    push(w0);
    push(w1);
    pb = pop_cyc.size();
    @(negedge clk);
    enable = 1'b1;
    wait_pop("rstmid", pb, pc);
    wait_cyc(pc + 2 + 10 * CPB + 4 * CPB + 1);
    check("rstmid_pre_tx", tx, 0);
    #1 rst = 1'b1;
    #1;
    check("rstmid_tx_async", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_words", words_sent, 0);
    exp_ws = '0;
    repeat (2) @(negedge clk);
    rb = rx_bytes.size();
    pb = pop_cyc.size();
    rst = 1'b0;
    wait_pop("rstmid_next", pb, pc);
    wait_idle("rstmid_next", 300);
    exp_ws = exp_ws + 16'd1;
    check("rstmid_nbytes", rx_bytes.size() - rb, 2);
    check_word("rstmid_next", rb, w1);
    if (rx_start.size() > rb)
      check("rstmid_latency", rx_start[rb] - pc, 2);
    check("rstmid_words_after", words_sent, 32'(exp_ws));

    // words_sent wraps from 0xFFFF to 0.
    @(negedge clk);
    force dut.words_sent = 16'hFFFF;
    @(negedge clk);
    release dut.words_sent;
    exp_ws = 16'hFFFF;
    w0 = 12'($urandom);
    rb = rx_bytes.size();
    push(w0);
    wait_idle("wrap", 300);
    exp_ws = exp_ws + 16'd1;
    check_word("wrap", rb, w0);
    check("wrap_words", words_sent, 32'(exp_ws));

    // Randomized bursts of queued words.
    for (int r = 0; r < 3; r++) begin
      enable = 1'b0;
      nw = int'($urandom_range(2, 4));
      for (int i = 0; i < nw; i++) begin
        ws[i] = 12'($urandom);
        push(ws[i]);
      end
      rb = rx_bytes.size();
      pb = pop_cyc.size();
      repeat (int'($urandom_range(1, 5))) @(negedge clk);
      enable = 1'b1;
      wait_idle("rand", nw * 100 + 50);
      exp_ws = exp_ws + 16'(nw);
      check("rand_nbytes", rx_bytes.size() - rb, 2 * nw);
      for (int i = 0; i < nw; i++) begin
        check_word("rand", rb + 2 * i, ws[i]);
        if (i > 0 && rx_start.size() > rb + 2 * i)
          check("rand_word_gap", rx_start[rb + 2 * i] - (rx_start[rb + 2 * i - 1] + 10 * CPB), 2);
      end
      check("rand_npops", pop_cyc.size() - pb, nw);
      check("rand_words", words_sent, 32'(exp_ws));
    end

    // Protocol-wide properties over the whole run.
    check("bad_frames", bad_frames, 0);
    check("rd_while_empty", rd_empty_viol, 0);
    check("rd_strobe_width", rd_long, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
